blk_mem_arbiter: RTL



---
 rtl/blk_mem_arbiter_pkg.sv | 28 ++
 rtl/blk_mem_arbiter_if.sv | 51 +++++
 rtl/blk_mem_arbiter_rr_arb2.sv | 42 ++++
 rtl/blk_mem_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/blk_mem_arbiter_pkg.sv
// Shared types and constants for the iCache/dCache block memory arbiter.
package blk_mem_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 32;
    localparam int unsigned BLK_WIDTH_DEF   = 256;
    localparam int unsigned MEM_LATENCY_DEF = 4;
    localparam int unsigned BLK_OFFSET_BITS = 5;
    localparam int unsigned CNT_WIDTH       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

    // Latched identity of the transaction in flight.
    typedef struct packed {
        gnt_t side;
        logic write;
    } txn_t;

endpackage

// File: rtl/blk_mem_arbiter_if.sv
// Cache request/response and memory port bundle; slave is the arbiter's view.
interface blk_mem_arbiter_if
    import blk_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned BLK_WIDTH  = BLK_WIDTH_DEF
);

    logic                  i_blk_read;
    logic                  i_blk_write;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [BLK_WIDTH-1:0]  i_wdata;
    logic [BLK_WIDTH-1:0]  i_rdata;
    logic                  i_done;

    logic                  d_blk_read;
    logic                  d_blk_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [BLK_WIDTH-1:0]  d_wdata;
    logic [BLK_WIDTH-1:0]  d_rdata;
    logic                  d_done;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BLK_WIDTH-1:0]  mem_wdata;
    logic [BLK_WIDTH-1:0]  mem_rdata;

    logic                  busy;

    modport slave (
        input  i_blk_read, i_blk_write, i_addr, i_wdata,
        output i_rdata, i_done,
        input  d_blk_read, d_blk_write, d_addr, d_wdata,
        output d_rdata, d_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output i_blk_read, i_blk_write, i_addr, i_wdata,
        input  i_rdata, i_done,
        output d_blk_read, d_blk_write, d_addr, d_wdata,
        input  d_rdata, d_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/blk_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the side that was not served last.
module blk_mem_arbiter_rr_arb2
    import blk_mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic req_d,
    input  logic update,
    input  gnt_t served,
    output gnt_t grant_c
);

    gnt_t last_grant_q;
    gnt_t last_grant_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= GNT_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (update) begin
            last_grant_d = served;
        end
    end

    // Reset leaves last_grant at I, so D wins the first tie.
    always_comb begin
        grant_c = GNT_I;
        if (req_i && req_d) begin
            grant_c = (last_grant_q == GNT_I) ? GNT_D : GNT_I;
        end else if (req_d) begin
            grant_c = GNT_D;
        end
    end

endmodule

// File: rtl/blk_mem_arbiter.sv
// Arbitrates iCache/dCache block reads and writes onto one fixed-latency memory port
// and returns data plus a one-cycle done pulse to the winning cache.
module blk_mem_arbiter
    import blk_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned BLK_WIDTH   = BLK_WIDTH_DEF,
    parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    blk_mem_arbiter_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~ADDR_WIDTH'((1 << BLK_OFFSET_BITS) - 1);
    localparam logic [CNT_WIDTH-1:0] LAT_LOAD = CNT_WIDTH'(MEM_LATENCY);

    state_t                state_q, state_d;
    txn_t                  txn_q, txn_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [BLK_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [BLK_WIDTH-1:0]  i_rdata_q, i_rdata_d;
    logic [BLK_WIDTH-1:0]  d_rdata_q, d_rdata_d;
    logic                  i_done_q, i_done_d;
    logic                  d_done_q, d_done_d;
    logic                  busy_q, busy_d;

    logic                  pend_i;
    logic                  pend_d;
    logic                  take;
    logic                  last_beat;
    logic                  arb_update;
    gnt_t                  gnt_c;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BLK_WIDTH-1:0]  sel_wdata;

    assign pend_i    = bus.i_blk_read | bus.i_blk_write;
    assign pend_d    = bus.d_blk_read | bus.d_blk_write;
    assign take      = (state_q == ST_IDLE) && (pend_i || pend_d);
    assign last_beat = (state_q == ST_WAIT) && (cnt_q == CNT_WIDTH'(1));

    blk_mem_arbiter_rr_arb2 u_rr_arb2 (
        .clk     (CLK),
        .rst_n   (RESET),
        .req_i   (pend_i),
        .req_d   (pend_d),
        .update  (arb_update),
        .served  (txn_q.side),
        .grant_c (gnt_c)
    );

    // Writeback has precedence over a read raised alongside it on the same side.
    assign sel_write = (gnt_c == GNT_D) ? bus.d_blk_write : bus.i_blk_write;
    assign sel_addr  = (gnt_c == GNT_D) ? bus.d_addr      : bus.i_addr;
    assign sel_wdata = (gnt_c == GNT_D) ? bus.d_wdata     : bus.i_wdata;

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (take) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (last_beat) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; outputs are registered one cycle ahead of their state.
    always_comb begin
        txn_d       = txn_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        arb_update  = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    txn_d.side  = gnt_c;
                    txn_d.write = sel_write;
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_write;
                    mem_addr_d  = sel_addr & ALIGN_MASK;
                    mem_wdata_d = sel_wdata;
                end
            end
            ST_ISSUE: begin
                cnt_d = LAT_LOAD;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (last_beat) begin
                    if (!txn_q.write) begin
                        if (txn_q.side == GNT_D) begin
                            d_rdata_d = bus.mem_rdata;
                        end else begin
                            i_rdata_d = bus.mem_rdata;
                        end
                    end
                    i_done_d = (txn_q.side == GNT_I);
                    d_done_d = (txn_q.side == GNT_D);
                end
            end
            ST_DONE: begin
                arb_update = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset drops any in-flight read without a done.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            txn_q       <= '0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            txn_q       <= txn_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.busy      = busy_q;

endmodule
